// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the button debouncer: FSM state encodings and the default
// stability threshold.
package btn_debounce_pulse_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } debounce_state_t;

    // The debounced level is high while resting high or while qualifying a release.
    function automatic logic is_high_side(input debounce_state_t s);
        return (s == IDLE_HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs; clears to zero on reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces a raw button into a clean level plus a one-cycle press pulse that
// serves as the toggle/enable source for the downstream counter.
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    output logic level_out,
    output logic pulse_out
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    debounce_state_t  state;
    debounce_state_t  state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             pulse_next;
    logic             s2;

    sync2 #(
        .WIDTH(1)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (btn_in),
        .q    (s2)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            level_out <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            level_out <= level_next;
            pulse_out <= pulse_next;
        end
    end

    // A wait state aborts with no partial credit as soon as the opposite value is seen.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE_LOW: begin
                if (s2) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase

        level_next = is_high_side(state_next);
        pulse_next = (state == WAIT_HIGH) && (state_next == IDLE_HIGH);
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse: a history-based reference predicts the
// debounced level/pulse per edge and each scenario task compares against it.
module tb_btn_debounce_pulse;
    import btn_debounce_pulse_pkg::*;

    localparam int STABLE = 4;

    typedef struct packed {
        logic level;
        logic pulse;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_in = 1'b0;
    logic level_out;
    logic pulse_out;
    logic [1:0] q;

    exp_t sb[$];
    bit   hist[$];
    bit   model_level;
    int   errors = 0;
    int   checks = 0;
    int   edge_total = 0;
    int   rel_edge = 0;

    btn_debounce_pulse #(
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_in   (btn_in),
        .level_out(level_out),
        .pulse_out(pulse_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_total <= edge_total + 1;

    // Downstream 2-bit toggle counter enabled by the press pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) q <= 2'b00;
        else if (pulse_out) q <= q + 2'b01;
    end

    function automatic int cur_edge();
        return edge_total - rel_edge;
    endfunction

    // Level flips once the last STABLE raw inputs all disagree with it; the effect
    // shows up two edges after the newest of those inputs.
    function automatic void model_push(input bit b);
        exp_t e;
        bit   run_ok;
        hist.push_back(b);
        if (hist.size() > STABLE) void'(hist.pop_front());
        run_ok = (hist.size() >= STABLE);
        for (int i = 0; i < STABLE; i++)
            if (run_ok && hist[hist.size() - 1 - i] == model_level) run_ok = 1'b0;
        e.pulse = run_ok && !model_level;
        if (run_ok) model_level = !model_level;
        e.level = model_level;
        sb.push_back(e);
    endfunction

    function automatic void reset_model();
        sb.delete();
        hist.delete();
        model_level = 1'b0;
        sb.push_back(2'b00);
        sb.push_back(2'b00);
        model_push(btn_in);
    endfunction

    task automatic test_reset();
        btn_in = 1'b0;
        reset  = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (level_out !== 1'b0 || pulse_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: level=%b pulse=%b expected 0 0", level_out, pulse_out);
        end
        checks++;
        if (dut.state !== IDLE_LOW || dut.cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: state=%b cnt=%0d expected 00 0", dut.state, dut.cnt);
        end
        reset    = 1'b1;
        rel_edge = edge_total;
        reset_model();
    endtask

    task automatic test_clean_press();
        exp_t e;
        int   pulses = 0;
        for (int j = 1; j <= 28; j++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (level_out !== e.level || pulse_out !== e.pulse) begin
                errors++;
                $display("[TB] FAIL clean_press edge %0d: level=%b pulse=%b expected %b %b",
                         cur_edge(), level_out, pulse_out, e.level, e.pulse);
            end
            if (pulse_out === 1'b1) pulses++;
            if (cur_edge() == 15) begin
                checks++;
                if (level_out !== 1'b1 || pulse_out !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL press_edge15: level=%b pulse=%b expected 1 1", level_out, pulse_out);
                end
            end
            if (cur_edge() == 16) begin
                checks++;
                if (level_out !== 1'b1 || pulse_out !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL press_edge16: level=%b pulse=%b expected 1 0", level_out, pulse_out);
                end
            end
            btn_in = (j >= 9);
            model_push(btn_in);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL press_pulse_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_release();
        exp_t e;
        int   pulses = 0;
        for (int j = 29; j <= 40; j++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (level_out !== e.level || pulse_out !== e.pulse) begin
                errors++;
                $display("[TB] FAIL release edge %0d: level=%b pulse=%b expected %b %b",
                         cur_edge(), level_out, pulse_out, e.level, e.pulse);
            end
            if (pulse_out === 1'b1) pulses++;
            if (cur_edge() == 34 || cur_edge() == 35) begin
                checks++;
                if (level_out !== (cur_edge() == 34)) begin
                    errors++;
                    $display("[TB] FAIL release_edge%0d: level=%b expected %b",
                             cur_edge(), level_out, cur_edge() == 34);
                end
            end
            btn_in = 1'b0;
            model_push(btn_in);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("[TB] FAIL release_pulse_count: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_threshold(input int run_len, input int want_pulses);
        exp_t e;
        bit   pat[$];
        int   pulses = 0;
        for (int i = 0; i < 3; i++) pat.push_back(1'b0);
        for (int i = 0; i < run_len; i++) pat.push_back(1'b1);
        for (int i = 0; i < 10; i++) pat.push_back(1'b0);
        foreach (pat[i]) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (level_out !== e.level || pulse_out !== e.pulse) begin
                errors++;
                $display("[TB] FAIL threshold_%0d edge %0d: level=%b pulse=%b expected %b %b",
                         run_len, cur_edge(), level_out, pulse_out, e.level, e.pulse);
            end
            if (pulse_out === 1'b1) pulses++;
            btn_in = pat[i];
            model_push(btn_in);
        end
        checks++;
        if (pulses != want_pulses) begin
            errors++;
            $display("[TB] FAIL threshold_%0d_pulses: got %0d expected %0d", run_len, pulses, want_pulses);
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        bit   pat[$];
        int   pulses = 0;
        int   rise_edge = -1;
        int   pulse_edge = -1;
        pat = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        foreach (pat[i]) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (level_out !== e.level || pulse_out !== e.pulse) begin
                errors++;
                $display("[TB] FAIL bounce edge %0d: level=%b pulse=%b expected %b %b",
                         cur_edge(), level_out, pulse_out, e.level, e.pulse);
            end
            if (pulse_out === 1'b1) begin
                pulses++;
                pulse_edge = cur_edge();
            end
            if (i == 10) rise_edge = cur_edge() + 1;
            btn_in = pat[i];
            model_push(btn_in);
        end
        checks++;
        if (pulses != 1 || pulse_edge != rise_edge + STABLE + 1) begin
            errors++;
            $display("[TB] FAIL bounce_pulse: count=%0d at edge %0d expected 1 at edge %0d",
                     pulses, pulse_edge, rise_edge + STABLE + 1);
        end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        int   pulses = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (level_out !== e.level || pulse_out !== e.pulse) begin
                errors++;
                $display("[TB] FAIL mid_wait edge %0d: level=%b pulse=%b expected %b %b",
                         cur_edge(), level_out, pulse_out, e.level, e.pulse);
            end
            btn_in = 1'b1;
            model_push(btn_in);
        end
        checks++;
        if (dut.state !== WAIT_HIGH || dut.cnt !== 2) begin
            errors++;
            $display("[TB] FAIL mid_wait_pre: state=%b cnt=%0d expected 01 2", dut.state, dut.cnt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (level_out !== 1'b0 || pulse_out !== 1'b0 || dut.s2 !== 1'b0 || dut.cnt !== '0) begin
            errors++;
            $display("[TB] FAIL mid_wait_reset: level=%b pulse=%b s2=%b cnt=%0d expected 0 0 0 0",
                     level_out, pulse_out, dut.s2, dut.cnt);
        end
        repeat (3) @(negedge clock);
        reset    = 1'b1;
        rel_edge = edge_total;
        reset_model();
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (level_out !== e.level || pulse_out !== e.pulse) begin
                errors++;
                $display("[TB] FAIL held_reset edge %0d: level=%b pulse=%b expected %b %b",
                         cur_edge(), level_out, pulse_out, e.level, e.pulse);
            end
            if (pulse_out === 1'b1) pulses++;
            model_push(btn_in);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL held_reset_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_counter_integration();
        exp_t e;
        btn_in = 1'b0;
        reset  = 1'b0;
        #1;
        checks++;
        if (level_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_from_high: level=%b expected 0", level_out);
        end
        repeat (2) @(negedge clock);
        reset    = 1'b1;
        rel_edge = edge_total;
        reset_model();
        for (int p = 1; p <= 3; p++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clock);
                e = sb.pop_front();
                checks++;
                if (level_out !== e.level || pulse_out !== e.pulse) begin
                    errors++;
                    $display("[TB] FAIL counter press %0d edge %0d: level=%b pulse=%b expected %b %b",
                             p, cur_edge(), level_out, pulse_out, e.level, e.pulse);
                end
                btn_in = (j < 6);
                model_push(btn_in);
            end
            checks++;
            if (q !== 2'(p)) begin
                errors++;
                $display("[TB] FAIL counter_q after press %0d: q=%b expected %b", p, q, 2'(p));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_threshold(STABLE, 1);
        test_threshold(STABLE - 1, 0);
        test_bounce();
        test_reset_mid_wait();
        test_counter_integration();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
